// File: rtl/lfb_pkg.sv
// ---------------------------------------------------------------------------
// lfb_pkg
// Shared definitions for the line fill buffer: line geometry, the fill
// state encoding and the wrapping word-index helper.
// ---------------------------------------------------------------------------
package lfb_pkg;

    localparam int LFB_WORDS = 16;
    localparam int LFB_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } lfb_state_t;

    // Word index of a beat: start offset plus beat count, wrapping 15 -> 0.
    function automatic logic [LFB_IDX_W-1:0] lfb_wrap_idx(
        input logic [LFB_IDX_W-1:0] base,
        input logic [LFB_IDX_W-1:0] off
    );
        return base + off;
    endfunction

endpackage

// File: rtl/line_fill_buffer.sv
// ---------------------------------------------------------------------------
// line_fill_buffer
// Assembles a 16-word cache line from single-word memory beats and holds it
// for the parent's 16:1 word-select mux.
//
// Optional feature macro: LFB_CRIT_FIRST_EN
//   defined   : memory returns the critical word first, wrapping round.
//   undefined : memory returns words 0..15 in order; the critical word is
//               still tracked and flagged when its beat arrives.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   req_valid     miss request, accepted while req_ready is high
//   req_word      critical word index of the request
//   req_ready     high in IDLE (decoded from state)
//   mem_read      memory read strobe, high throughout FILL (decoded)
//   mem_resp      one data beat valid this cycle
//   mem_rdata     beat data
//   line          assembled line, line[i] = word i
//   word_valid    bit i set once line[i] captured in the current fill
//   crit_sel      latched critical word index (mux select)
//   crit_valid    one-cycle pulse: line[crit_sel] now holds the new data
//   line_valid    one-cycle pulse: all 16 words captured
// ---------------------------------------------------------------------------
module line_fill_buffer
    import lfb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 req_valid,
    input  logic [LFB_IDX_W-1:0]                 req_word,
    output logic                                 req_ready,
    output logic                                 mem_read,
    input  logic                                 mem_resp,
    input  logic [WIDTH-1:0]                     mem_rdata,
    output logic [LFB_WORDS-1:0][WIDTH-1:0]      line,
    output logic [LFB_WORDS-1:0]                 word_valid,
    output logic [LFB_IDX_W-1:0]                 crit_sel,
    output logic                                 crit_valid,
    output logic                                 line_valid
);

    lfb_state_t             state;
    lfb_state_t             next_state;
    logic [LFB_IDX_W-1:0]   start;
    logic [LFB_IDX_W-1:0]   cnt;
    logic [LFB_IDX_W-1:0]   wr_idx;
    logic [LFB_IDX_W-1:0]   start_sel;
    logic                   accept;
    logic                   beat;
    logic                   last_beat;

    assign wr_idx    = lfb_wrap_idx(start, cnt);
    assign accept    = (state == IDLE) && req_valid;
    assign beat      = (state == FILL) && mem_resp;
    assign last_beat = beat && (cnt == 4'd15);

`ifdef LFB_CRIT_FIRST_EN
    assign start_sel = req_word;
`else
    assign start_sel = 4'd0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the two state-decoded handshake outputs.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    next_state = FILL;
                end else begin
                    next_state = IDLE;
                end
            end
            FILL: begin
                mem_read = 1'b1;
                if (mem_resp && (cnt == 4'd15)) begin
                    next_state = DONE;
                end else begin
                    next_state = FILL;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request latch, beat counter, line storage and registered pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start      <= 4'd0;
            cnt        <= 4'd0;
            crit_sel   <= 4'd0;
            line       <= '0;
            word_valid <= 16'd0;
            crit_valid <= 1'b0;
            line_valid <= 1'b0;
        end else begin
            // The critical-word flag compares against the latched index, so
            // it works for both in-order and critical-first return.
            crit_valid <= beat && (wr_idx == crit_sel);
            line_valid <= last_beat;
            if (accept) begin
                crit_sel   <= req_word;
                start      <= start_sel;
                cnt        <= 4'd0;
                word_valid <= 16'd0;
            end else if (beat) begin
                line[wr_idx]       <= mem_rdata;
                word_valid[wr_idx] <= 1'b1;
                cnt                <= cnt + 4'd1;
            end else begin
                cnt <= cnt;
            end
        end
    end

endmodule

// File: tb/tb_line_fill_buffer.sv
// ---------------------------------------------------------------------------
// tb_line_fill_buffer
// Self-checking bench for line_fill_buffer: a short table of hand-computed
// vectors, a mid-fill reset, directed fills from the test plan and random
// fills with gaps and stray inputs, all against a line-level reference model.
// ---------------------------------------------------------------------------
module tb_line_fill_buffer;

    logic               clk;
    logic               rst;
    logic               req_valid;
    logic [3:0]         req_word;
    logic               req_ready;
    logic               mem_read;
    logic               mem_resp;
    logic [31:0]        mem_rdata;
    logic [15:0][31:0]  line;
    logic [15:0]        word_valid;
    logic [3:0]         crit_sel;
    logic               crit_valid;
    logic               line_valid;

    int checks = 0;
    int errors = 0;
    int cv_count = 0;

    line_fill_buffer #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_word   (req_word),
        .req_ready  (req_ready),
        .mem_read   (mem_read),
        .mem_resp   (mem_resp),
        .mem_rdata  (mem_rdata),
        .line       (line),
        .word_valid (word_valid),
        .crit_sel   (crit_sel),
        .crit_valid (crit_valid),
        .line_valid (line_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 filling, 2 done.
    int                 m_phase;
    int                 m_nb;
    int                 m_start;
    logic [3:0]         m_crit;
    logic [15:0]        m_wv;
    logic [15:0][31:0]  m_line;
    logic               e_cv;
    logic               e_lv;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_line(input logic [15:0][31:0] act, input logic [15:0][31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL line: got %h expected %h", act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_nb    = 0;
        m_start = 0;
        m_crit  = 4'd0;
        m_wv    = 16'd0;
        m_line  = '0;
        e_cv    = 1'b0;
        e_lv    = 1'b0;
    endtask

    task automatic model_step(input logic rv, input logic [3:0] rw, input logic mr, input logic [31:0] md);
        int w;
        e_cv = 1'b0;
        e_lv = 1'b0;
        if (m_phase == 0) begin
            if (rv) begin
                m_crit = rw;
`ifdef LFB_CRIT_FIRST_EN
                m_start = int'(rw);
`else
                m_start = 0;
`endif
                m_nb    = 0;
                m_wv    = 16'd0;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (mr) begin
                w = (m_start + m_nb) % 16;
                m_line[w] = md;
                m_wv[w]   = 1'b1;
                if (w == int'(m_crit)) e_cv = 1'b1;
                m_nb++;
                if (m_nb == 16) begin
                    m_phase = 2;
                    e_lv    = 1'b1;
                end
            end
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic compare_all();
        check("req_ready", 64'(req_ready), 64'(m_phase == 0));
        check("mem_read", 64'(mem_read), 64'(m_phase == 1));
        check("word_valid", 64'(word_valid), 64'(m_wv));
        check("wv_popcount", 64'($countones(word_valid)), 64'(m_nb));
        check("crit_sel", 64'(crit_sel), 64'(m_crit));
        check("crit_valid", 64'(crit_valid), 64'(e_cv));
        check("line_valid", 64'(line_valid), 64'(e_lv));
        check_line(line, m_line);
    endtask

    // One clock: drive inputs, advance the model at the edge, compare after it.
    task automatic cycle(input logic rv, input logic [3:0] rw, input logic mr, input logic [31:0] md);
        req_valid = rv;
        req_word  = rw;
        mem_resp  = mr;
        mem_rdata = md;
        @(posedge clk);
        model_step(rv, rw, mr, md);
        #1;
        if (crit_valid) cv_count++;
        compare_all();
    endtask

    // Full fill: request, 16 beats (data base+k or random), gaps up to maxgap
    // with stray requests, then stray inputs during DONE and IDLE.
    task automatic fill(input logic [3:0] rw, input logic [31:0] base, input int maxgap, input bit rnd);
        int g;
        cycle(1'b1, rw, 1'b0, 32'd0);
        for (int k = 0; k < 16; k++) begin
            g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            for (int j = 0; j < g; j++) begin
                cycle(1'($urandom % 2), 4'($urandom), 1'b0, $urandom);
            end
            cycle(1'($urandom % 2), 4'($urandom), 1'b1, rnd ? $urandom : base + 32'(k));
        end
        cycle(1'b1, 4'($urandom), 1'b1, $urandom);
        cycle(1'b0, 4'd0, 1'b1, $urandom);
    endtask

    typedef struct {
        logic        rv;
        logic [3:0]  rw;
        logic        mr;
        logic [31:0] md;
        logic        e_ready;
        logic        e_mread;
        logic        e_cv;
        logic [15:0] e_wv;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int cv0;
        int s;
        logic [31:0] w;

        // req_word 0 keeps the start offset 0 in either build.
        vecs[0] = '{1'b0, 4'd0, 1'b1, 32'h55, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[1] = '{1'b1, 4'd0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[2] = '{1'b0, 4'd0, 1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 16'h0001};
        vecs[3] = '{1'b0, 4'd0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 16'h0001};
        vecs[4] = '{1'b1, 4'd5, 1'b1, 32'h22, 1'b0, 1'b1, 1'b0, 16'h0003};
        vecs[5] = '{1'b0, 4'd0, 1'b1, 32'h33, 1'b0, 1'b1, 1'b0, 16'h0007};
        vecs[6] = '{1'b0, 4'd0, 1'b1, 32'h44, 1'b0, 1'b1, 1'b0, 16'h000F};
        vecs[7] = '{1'b0, 4'd0, 1'b1, 32'h55, 1'b0, 1'b1, 1'b0, 16'h001F};

        req_valid = 1'b0;
        req_word  = 4'd0;
        mem_resp  = 1'b0;
        mem_rdata = 32'd0;
        rst       = 1'b1;
        model_reset();
        #12;
        compare_all();
        rst = 1'b0;
        #2;

        // Table vectors, ending five beats into a fill.
        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].rv, vecs[i].rw, vecs[i].mr, vecs[i].md);
            check("tbl_ready", 64'(req_ready), 64'(vecs[i].e_ready));
            check("tbl_mem_read", 64'(mem_read), 64'(vecs[i].e_mread));
            check("tbl_crit_valid", 64'(crit_valid), 64'(vecs[i].e_cv));
            check("tbl_word_valid", 64'(word_valid), 64'(vecs[i].e_wv));
        end
        check("tbl_line4", 64'(line[4]), 64'h55);

        // Asynchronous reset in the middle of the fill.
        rst = 1'b1;
        #2;
        model_reset();
        check("rst_word_valid", 64'(word_valid), 64'h0);
        check("rst_line_zero", 64'(line == '0), 64'h1);
        check("rst_req_ready", 64'(req_ready), 64'h1);
        check("rst_mem_read", 64'(mem_read), 64'h0);
        compare_all();
        #3;
        rst = 1'b0;
        cycle(1'b0, 4'd0, 1'b0, 32'd0);

`ifdef LFB_CRIT_FIRST_EN
        cv0 = cv_count;
        fill(4'hD, 32'h100, 0, 1'b0);
        check("cf_line_D", 64'(line[13]), 64'h100);
        check("cf_line_E", 64'(line[14]), 64'h101);
        check("cf_line_0", 64'(line[0]), 64'h103);
        check("cf_line_C", 64'(line[12]), 64'h10F);
        check("cf_crit_pulses", 64'(cv_count - cv0), 64'd1);
        fill(4'hF, 32'h200, 0, 1'b0);
        check("wrap_line_F", 64'(line[15]), 64'h200);
        check("wrap_line_0", 64'(line[0]), 64'h201);
        check("wrap_line_E", 64'(line[14]), 64'h20F);
`else
        cv0 = cv_count;
        fill(4'h3, 32'hA0, 0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            w = 32'hA0 + 32'(i);
            check("ord_line", 64'(line[i]), 64'(w));
        end
        check("ord_crit_pulses", 64'(cv_count - cv0), 64'd1);
`endif

        // Gapped fill: final line equals the gapless layout.
        fill(4'h7, 32'h700, 3, 1'b0);
`ifdef LFB_CRIT_FIRST_EN
        s = 7;
`else
        s = 0;
`endif
        for (int k = 0; k < 16; k++) begin
            w = 32'h700 + 32'(k);
            check("gap_line", 64'(line[(s + k) % 16]), 64'(w));
        end

        // Random fills against the model.
        for (int n = 0; n < 8; n++) begin
            cv0 = cv_count;
            fill(4'($urandom), 32'd0, 3, 1'b1);
            check("rnd_crit_pulses", 64'(cv_count - cv0), 64'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
